aidan_mcnay_deserializer: RTL and testbench

Parametrised serial-to-parallel converter with latency-insensitive val/rdy handshakes on both sides.
- Accepts one bit per handshake and assembles nbits-wide words.
- Bit order is selectable (MSB-first or LSB-first).
- A one-word output buffer lets the input keep accepting bits while the consumer stalls.
- Sits between serial front-end logic (bit streams from an input pin or a shift interface) and word-level datapaths such as the prime-detection core.

---
 rtl/aidan_mcnay_deserializer.sv | 108 ++++++++++
 tb/tb_aidan_mcnay_deserializer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/aidan_mcnay_deserializer.sv
// Serial-to-parallel converter: assembles nbits-wide words one bit per val/rdy handshake,
// with a one-word output buffer so the input side keeps running while the consumer stalls.
module aidan_mcnay_deserializer #(
    parameter int nbits     = 16,
    parameter int msb_first = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         in_val,
    output logic                         in_rdy,
    input  logic                         data_in,
    output logic                         out_val,
    input  logic                         out_rdy,
    output logic [nbits-1:0]             data_out,
    output logic [$clog2(nbits+1)-1:0]   bit_count
);

    localparam int CW = $clog2(nbits + 1);
    localparam logic [CW-1:0] FULL_C = CW'(nbits);
    localparam logic [CW-1:0] LAST_C = CW'(nbits - 1);

    logic [nbits-1:0] shift_q, shift_d;
    logic [nbits-1:0] buf_q, buf_d;
    logic [CW-1:0]    count_q, count_d;
    logic             out_val_q, out_val_d;
    logic [nbits-1:0] shifted;

    logic full;
    logic in_xfer;
    logic out_xfer;
    logic drain;

    // Next shift-register value if a bit is accepted this cycle.
    genvar gi;
    generate
        for (gi = 0; gi < nbits; gi++) begin : g_shift
            if (msb_first != 0) begin : g_msb
                if (gi == 0) begin : g_in
                    assign shifted[gi] = data_in;
                end else begin : g_mv
                    assign shifted[gi] = shift_q[gi-1];
                end
            end else begin : g_lsb
                if (gi == nbits - 1) begin : g_in
                    assign shifted[gi] = data_in;
                end else begin : g_mv
                    assign shifted[gi] = shift_q[gi+1];
                end
            end
        end
    endgenerate

    assign full     = (count_q == FULL_C);
    assign in_rdy   = !clear && !full;
    assign in_xfer  = in_val && in_rdy;
    assign out_xfer = out_val_q && out_rdy;
    assign drain    = !out_val_q || out_rdy;

    always_comb begin
        shift_d   = shift_q;
        buf_d     = buf_q;
        count_d   = count_q;
        out_val_d = out_xfer ? 1'b0 : out_val_q;

        if (clear) begin
            shift_d = '0;
            count_d = '0;
        end else if (in_xfer) begin
            shift_d = shifted;
            if (count_q == LAST_C) begin
                if (drain) begin
                    buf_d     = shifted;
                    out_val_d = 1'b1;
                    count_d   = '0;
                end else begin
                    count_d = FULL_C;
                end
            end else begin
                count_d = count_q + CW'(1);
            end
        end else if (full && drain) begin
            // Pending complete word moves into the buffer as soon as it frees up.
            buf_d     = shift_q;
            out_val_d = 1'b1;
            count_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q   <= '0;
            buf_q     <= '0;
            count_q   <= '0;
            out_val_q <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            buf_q     <= buf_d;
            count_q   <= count_d;
            out_val_q <= out_val_d;
        end
    end

    assign out_val   = out_val_q;
    assign data_out  = buf_q;
    assign bit_count = count_q;

endmodule

// File: tb/tb_aidan_mcnay_deserializer.sv
// Directed bench for the deserializer: a 16-bit MSB-first instance and an 8-bit LSB-first instance.
module tb_aidan_mcnay_deserializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        clear16, in_val16, data_in16, out_rdy16;
    logic        in_rdy16, out_val16;
    logic [15:0] data_out16;
    logic [4:0]  bit_count16;

    logic        clear8, in_val8, data_in8, out_rdy8;
    logic        in_rdy8, out_val8;
    logic [7:0]  data_out8;
    logic [3:0]  bit_count8;

    int n_vec = 0;
    int n_err = 0;

    aidan_mcnay_deserializer #(.nbits(16), .msb_first(1)) dut16 (
        .clk(clk), .reset(reset), .clear(clear16), .in_val(in_val16), .in_rdy(in_rdy16),
        .data_in(data_in16), .out_val(out_val16), .out_rdy(out_rdy16),
        .data_out(data_out16), .bit_count(bit_count16)
    );

    aidan_mcnay_deserializer #(.nbits(8), .msb_first(0)) dut8 (
        .clk(clk), .reset(reset), .clear(clear8), .in_val(in_val8), .in_rdy(in_rdy8),
        .data_in(data_in8), .out_val(out_val8), .out_rdy(out_rdy8),
        .data_out(data_out8), .bit_count(bit_count8)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #1;
        n_vec++; if (out_val16 !== 1'b0) begin n_err++; $display("FAIL reset_out_val16 got %b want 0", out_val16); end
        n_vec++; if (data_out16 !== 16'h0000) begin n_err++; $display("FAIL reset_data_out16 got %h want 0000", data_out16); end
        n_vec++; if (bit_count16 !== 5'd0) begin n_err++; $display("FAIL reset_bit_count16 got %0d want 0", bit_count16); end
        n_vec++; if (in_rdy16 !== 1'b1) begin n_err++; $display("FAIL reset_in_rdy16 got %b want 1", in_rdy16); end
        n_vec++; if (out_val8 !== 1'b0) begin n_err++; $display("FAIL reset_out_val8 got %b want 0", out_val8); end
        n_vec++; if (in_rdy8 !== 1'b1) begin n_err++; $display("FAIL reset_in_rdy8 got %b want 1", in_rdy8); end
        tick;
        tick;
        reset = 1'b0;
        tick;
        n_vec++; if (bit_count16 !== 5'd0) begin n_err++; $display("FAIL post_reset_bit_count16 got %0d want 0", bit_count16); end
        $display("test_reset done");
    endtask

    task automatic test_msb_stream;
        logic [15:0] w;
        w = 16'hB5A3;
        out_rdy16 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_vec++; if (bit_count16 !== 5'(i)) begin n_err++; $display("FAIL t1_bit_count[%0d] got %0d want %0d", i, bit_count16, i); end
            n_vec++; if (out_val16 !== 1'b0) begin n_err++; $display("FAIL t1_early_out_val[%0d] got %b want 0", i, out_val16); end
            in_val16  = 1'b1;
            data_in16 = w[15-i];
            tick;
        end
        in_val16 = 1'b0;
        n_vec++; if (out_val16 !== 1'b1) begin n_err++; $display("FAIL t1_out_val got %b want 1", out_val16); end
        n_vec++; if (data_out16 !== 16'hB5A3) begin n_err++; $display("FAIL t1_data_out got %h want b5a3", data_out16); end
        n_vec++; if (bit_count16 !== 5'd0) begin n_err++; $display("FAIL t1_bit_count_wrap got %0d want 0", bit_count16); end
        tick;
        n_vec++; if (out_val16 !== 1'b0) begin n_err++; $display("FAIL t1_consumed_out_val got %b want 0", out_val16); end
        n_vec++; if (data_out16 !== 16'hB5A3) begin n_err++; $display("FAIL t1_data_kept got %h want b5a3", data_out16); end
        $display("test_msb_stream word b5a3 -> %h", data_out16);
    endtask

    task automatic test_lsb_first;
        logic [7:0] p;
        out_rdy8 = 1'b1;
        p = 8'h01;
        for (int i = 0; i < 8; i++) begin
            in_val8 = 1'b1; data_in8 = p[i]; tick;
        end
        in_val8 = 1'b0;
        n_vec++; if (out_val8 !== 1'b1) begin n_err++; $display("FAIL t2a_out_val got %b want 1", out_val8); end
        n_vec++; if (data_out8 !== 8'h01) begin n_err++; $display("FAIL t2a_data_out got %h want 01", data_out8); end
        p = 8'h80;
        for (int i = 0; i < 8; i++) begin
            in_val8 = 1'b1; data_in8 = p[i]; tick;
        end
        in_val8 = 1'b0;
        n_vec++; if (out_val8 !== 1'b1) begin n_err++; $display("FAIL t2b_out_val got %b want 1", out_val8); end
        n_vec++; if (data_out8 !== 8'h80) begin n_err++; $display("FAIL t2b_data_out got %h want 80", data_out8); end
        tick;
        $display("test_lsb_first words 01,80 -> last %h", data_out8);
    endtask

    task automatic test_backpressure;
        logic [31:0] w;
        w = {16'h1234, 16'hABCD};
        out_rdy16 = 1'b0;
        for (int i = 0; i < 32; i++) begin
            n_vec++; if (in_rdy16 !== 1'b1) begin n_err++; $display("FAIL t3_in_rdy[%0d] got %b want 1", i, in_rdy16); end
            in_val16 = 1'b1; data_in16 = w[31-i]; tick;
            if (i == 15) begin
                n_vec++; if (out_val16 !== 1'b1) begin n_err++; $display("FAIL t3_first_out_val got %b want 1", out_val16); end
                n_vec++; if (data_out16 !== 16'h1234) begin n_err++; $display("FAIL t3_first_data got %h want 1234", data_out16); end
            end
        end
        in_val16 = 1'b0;
        tick;
        n_vec++; if (bit_count16 !== 5'd16) begin n_err++; $display("FAIL t3_full_count got %0d want 16", bit_count16); end
        n_vec++; if (in_rdy16 !== 1'b0) begin n_err++; $display("FAIL t3_full_in_rdy got %b want 0", in_rdy16); end
        n_vec++; if (data_out16 !== 16'h1234) begin n_err++; $display("FAIL t3_held_data got %h want 1234", data_out16); end
        out_rdy16 = 1'b1;
        tick;
        out_rdy16 = 1'b0;
        n_vec++; if (out_val16 !== 1'b1) begin n_err++; $display("FAIL t3_reload_out_val got %b want 1", out_val16); end
        n_vec++; if (data_out16 !== 16'hABCD) begin n_err++; $display("FAIL t3_reload_data got %h want abcd", data_out16); end
        n_vec++; if (bit_count16 !== 5'd0) begin n_err++; $display("FAIL t3_reload_count got %0d want 0", bit_count16); end
        n_vec++; if (in_rdy16 !== 1'b1) begin n_err++; $display("FAIL t3_reload_in_rdy got %b want 1", in_rdy16); end
        tick;
        n_vec++; if (out_val16 !== 1'b1) begin n_err++; $display("FAIL t3_stall_out_val got %b want 1", out_val16); end
        out_rdy16 = 1'b1;
        tick;
        n_vec++; if (out_val16 !== 1'b0) begin n_err++; $display("FAIL t3_drain_out_val got %b want 0", out_val16); end
        n_vec++; if (data_out16 !== 16'hABCD) begin n_err++; $display("FAIL t3_drain_data got %h want abcd", data_out16); end
        $display("test_backpressure words 1234,abcd -> last %h", data_out16);
    endtask

    task automatic test_back_to_back;
        logic [15:0] words [3];
        logic        exp_val;
        words[0] = 16'h0001; words[1] = 16'hFFFF; words[2] = 16'h8000;
        out_rdy16 = 1'b1;
        for (int k = 0; k < 48; k++) begin
            n_vec++; if (in_rdy16 !== 1'b1) begin n_err++; $display("FAIL t4_in_rdy[%0d] got %b want 1", k, in_rdy16); end
            in_val16 = 1'b1; data_in16 = words[k/16][15-(k%16)]; tick;
            exp_val = ((k % 16) == 15);
            n_vec++; if (out_val16 !== exp_val) begin n_err++; $display("FAIL t4_out_val[%0d] got %b want %b", k, out_val16, exp_val); end
            if (exp_val) begin
                n_vec++; if (data_out16 !== words[k/16]) begin n_err++; $display("FAIL t4_data[%0d] got %h want %h", k/16, data_out16, words[k/16]); end
            end
        end
        in_val16 = 1'b0;
        tick;
        $display("test_back_to_back words 0001,ffff,8000 -> last %h", data_out16);
    endtask

    task automatic test_clear;
        logic [15:0] w;
        out_rdy16 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_val16 = 1'b1; data_in16 = 1'b1; tick;
        end
        n_vec++; if (bit_count16 !== 5'd5) begin n_err++; $display("FAIL t5_partial_count got %0d want 5", bit_count16); end
        clear16 = 1'b1; in_val16 = 1'b1; data_in16 = 1'b1;
        #1;
        n_vec++; if (in_rdy16 !== 1'b0) begin n_err++; $display("FAIL t5_clear_in_rdy got %b want 0", in_rdy16); end
        tick;
        clear16 = 1'b0; in_val16 = 1'b0;
        n_vec++; if (bit_count16 !== 5'd0) begin n_err++; $display("FAIL t5_clear_count got %0d want 0", bit_count16); end
        w = 16'h00FF;
        for (int i = 0; i < 16; i++) begin
            in_val16 = 1'b1; data_in16 = w[15-i]; tick;
        end
        in_val16 = 1'b0;
        n_vec++; if (out_val16 !== 1'b1) begin n_err++; $display("FAIL t5_out_val got %b want 1", out_val16); end
        n_vec++; if (data_out16 !== 16'h00FF) begin n_err++; $display("FAIL t5_data got %h want 00ff", data_out16); end
        tick;
        $display("test_clear word 00ff -> %h", data_out16);
    endtask

    task automatic test_async_reset;
        logic [15:0] w;
        w = 16'h5555;
        out_rdy16 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_val16 = 1'b1; data_in16 = w[15-i]; tick;
        end
        for (int i = 0; i < 9; i++) begin
            in_val16 = 1'b1; data_in16 = 1'b1; tick;
        end
        in_val16 = 1'b0;
        n_vec++; if (out_val16 !== 1'b1) begin n_err++; $display("FAIL t6_pre_out_val got %b want 1", out_val16); end
        n_vec++; if (data_out16 !== 16'h5555) begin n_err++; $display("FAIL t6_pre_data got %h want 5555", data_out16); end
        n_vec++; if (bit_count16 !== 5'd9) begin n_err++; $display("FAIL t6_pre_count got %0d want 9", bit_count16); end
        #2;
        reset = 1'b1;
        #1;
        n_vec++; if (out_val16 !== 1'b0) begin n_err++; $display("FAIL t6_out_val got %b want 0", out_val16); end
        n_vec++; if (bit_count16 !== 5'd0) begin n_err++; $display("FAIL t6_count got %0d want 0", bit_count16); end
        n_vec++; if (data_out16 !== 16'h0000) begin n_err++; $display("FAIL t6_data got %h want 0000", data_out16); end
        n_vec++; if (in_rdy16 !== 1'b1) begin n_err++; $display("FAIL t6_in_rdy got %b want 1", in_rdy16); end
        tick;
        reset = 1'b0;
        tick;
        n_vec++; if (bit_count16 !== 5'd0) begin n_err++; $display("FAIL t6_post_count got %0d want 0", bit_count16); end
        $display("test_async_reset mid-word reset -> data %h count %0d", data_out16, bit_count16);
    endtask

    initial begin
        reset = 1'b1;
        clear16 = 1'b0; in_val16 = 1'b0; data_in16 = 1'b0; out_rdy16 = 1'b0;
        clear8  = 1'b0; in_val8  = 1'b0; data_in8  = 1'b0; out_rdy8  = 1'b0;
        test_reset;
        test_msb_stream;
        test_lsb_first;
        test_backpressure;
        test_back_to_back;
        test_clear;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
